cp0_unit: RTL
=============

# cp0_unit

System-control coprocessor (CP0) for the five-stage pipelined MIPS core. It sits at the memory stage and consumes the exception code that the pipeline accumulates through decode, ALU and memory checks. It merges that code with hardware interrupt lines and raises `Req` to flush the pipeline and redirect fetch to the handler. `Req` also freezes the multiply/divide unit's HI/LO and busy state. It holds SR, Cause, EPC and PRId, serves `mfc0`/`mtc0`, and clears EXL on `eret`.

## Interface
- `PRID_VALUE`, default 32'h0000_7000: read-only value of register 15.
- `HANDLER_PC`, default 32'h0000_4180: exported fetch target while `Req` is high.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `A1` in 5: CP0 register number for `mfc0` read.
- `A2` in 5: CP0 register number for `mtc0` write.
- `DIn` in 32: `mtc0` write data.
- `WE` in 1: `mtc0` write enable (instruction in M stage).
- `VPC` in 32: PC of the M-stage instruction (victim).
- `BDIn` in 1: M-stage instruction is in a branch delay slot.
- `ExcCodeIn` in 5: accumulated exception code; 0 (`Int`) means none.
- `HWInt` in 6: hardware interrupt lines, level-sensitive.
- `EXLClr` in 1: `eret` in M stage.
- `DOut` out 32: read data for `A1`.
- `EPCOut` out 32: EPC (with write bypass) for `eret`.
- `HandlerPC` out 32: equals `HANDLER_PC`.
- `Req` out 1: take exception/interrupt this cycle.

## Operation
- **SR (reg 12)**
  - Implemented bits: IM = [15:10], EXL = [1], IE = [0].
  - All other bits read 0 and ignore writes.
- **Cause (reg 13)**
  - Implemented bits: BD = [31], IP = [15:10], ExcCode = [6:2].
  - Read-only to `mtc0`.
- **EPC (reg 14)**
  - Full 32 bits, writable.
- **PRId (reg 15)**
  - Constant `PRID_VALUE`.
- **Other registers:** reads return 0; writes are ignored.
- **Interrupt and exception requests**
  - IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
  - ExcReq = (ExcCodeIn != 0) & !SR.EXL.
  - Req = IntReq | ExcReq. Combinational from current inputs and registered SR.
- **Priority:** when IntReq and ExcReq are both high, the interrupt wins and the recorded ExcCode is 0.
- **On a clock edge with Req = 1**
  - SR.EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? VPC - 4 : VPC, with bits [1:0] forced to 0.
  - A simultaneous `WE` is discarded (the faulting `mtc0` does not commit).
  - A simultaneous `EXLClr` is ignored.
- **On a clock edge with Req = 0**
  - If `WE`, write `DIn` into `A2` (masked as above).
  - If `EXLClr`, then SR.EXL <= 0. `EXLClr` overrides an `mtc0` writing SR.EXL in the same cycle.
- **Cause.IP:** loaded from `HWInt` on every edge, regardless of Req or EXL.
- **DOut:** combinational read of the registered values; no write-through.
- **EPCOut bypass:** if `WE & A2 == 14 & !Req`, EPCOut = {DIn[31:2], 2'b00}; otherwise EPCOut = EPC. This covers an `mtc0 EPC` immediately followed by `eret`.
- **No nested exceptions:** while EXL = 1, Req stays 0 regardless of inputs.

## Timing
- **Reset values (asynchronous):** SR = 0, Cause = 0, EPC = 0. Hence Req = 0, DOut reflects zeros, and EPCOut = 0.
- **Req latency:** 0 cycles (same-cycle combinational). Fetch redirects, and pipeline registers flush, on the edge that ends that cycle.
- **Register update latency:** 1 edge. State is visible on DOut the cycle after the edge.
- **Reset asserted mid-operation:** all registers clear immediately, without waiting for `clk`; Req drops in the same cycle.
- **IP sampling:** IP reflects HWInt as of the previous edge.
- **Interrupt window:** IntReq re-evaluates every cycle. An interrupt that appears while EXL = 1 is taken in the first cycle after EXL clears, provided it is still asserted and unmasked.

## Test plan
- **Reset:** assert `reset` mid-cycle with SR = 32'h0000_fc03 loaded -> SR, Cause, EPC = 0 and Req = 0 before the next edge.
- **Overflow exception:** ExcCodeIn = 12, VPC = 32'h0000_3010, BDIn = 0, SR = 0 -> Req = 1 that cycle. Next cycle: Cause[6:2] = 12, EPC = 32'h0000_3010, SR.EXL = 1, and Req = 0 even with ExcCodeIn still 12.
- **Delay-slot exception:** ExcCodeIn = 4, VPC = 32'h0000_3024, BDIn = 1 -> EPC = 32'h0000_3020 and Cause[31] = 1.
- **Interrupt priority:** SR = 32'h0000_0401, HWInt = 6'b000001, ExcCodeIn = 10 in the same cycle -> Req = 1, Cause.ExcCode = 0, and Cause.IP = 6'b000001 after the edge.
- **Write bypass and eret:** `mtc0` EPC = 32'h0000_3047 -> EPCOut = 32'h0000_3044 that cycle. Next cycle, `EXLClr` with EXL = 1 -> EXL = 0 after the edge.
- **Faulting write:** `WE`, A2 = 12, DIn = 32'h0000_fc01 while ExcCodeIn = 5 -> SR keeps its old IM/IE, EXL = 1, and the write is discarded.

Source files
------------

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Brief    : MIPS system-control coprocessor (SR, Cause, EPC, PRId), exception
//            and interrupt request generation for the M stage.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_7000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic [31:0] HandlerPC,
    output logic        Req
);

    localparam logic [4:0]  c_REG_SR    = 5'd12;
    localparam logic [4:0]  c_REG_CAUSE = 5'd13;
    localparam logic [4:0]  c_REG_EPC   = 5'd14;
    localparam logic [4:0]  c_REG_PRID  = 5'd15;
    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_victim_pc;

    assign w_int_req   = (|(HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req   = (ExcCodeIn != 5'd0) & ~r_exl;
    assign Req         = w_int_req | w_exc_req;
    assign HandlerPC   = HANDLER_PC;
    // A delay-slot victim restarts at its branch so the branch is re-executed.
    assign w_victim_pc = BDIn ? (VPC - 32'd4) : VPC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                r_exl      <= 1'b1;
                r_exc_code <= w_int_req ? 5'd0 : ExcCodeIn;
                r_bd       <= BDIn;
                r_epc      <= w_victim_pc & c_WORD_MASK;
            end else begin
                if (WE) begin
                    case (A2)
                        c_REG_SR: begin
                            r_im  <= DIn[15:10];
                            r_exl <= DIn[1];
                            r_ie  <= DIn[0];
                        end
                        c_REG_EPC: r_epc <= DIn;
                        default: ;
                    endcase
                end
                // eret wins over an mtc0 to SR.EXL in the same cycle.
                if (EXLClr) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (A1)
            c_REG_SR:    DOut = {16'd0, r_im, 8'd0, r_exl, r_ie};
            c_REG_CAUSE: DOut = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
            c_REG_EPC:   DOut = r_epc;
            c_REG_PRID:  DOut = PRID_VALUE;
            default:     DOut = 32'd0;
        endcase
    end

    // Bypass lets an eret right behind mtc0 EPC return to the new target.
    always_comb begin
        EPCOut = r_epc;
        if (WE && (A2 == c_REG_EPC) && !Req) begin
            EPCOut = DIn & c_WORD_MASK;
        end
    end

endmodule
`default_nettype wire
